cordic_job_sequencer: RTL and testbench
=======================================

// Module: cordic_job_sequencer
// PURPOSE
//   Upstream feeder for the CORDIC core. Accepts (mode, x, y) jobs on a valid/ready port and buffers them in a small FIFO.
//   Launches one job at a time on the core's start/mode/in_port0/in_port1 inputs, waits for done, and captures out_port0/1.
//   Returns each result, tagged with its mode and an error flag, on a valid/ready response port.
//   Sits between the host/bus logic and the CORDIC top level, in the same clock domain as the core's clka.
// PARAMETERS
//   DATA_W      8    operand/result width; matches core in/out ports
//   FIFO_DEPTH  4    job FIFO entries; power of two, >=2
//   TIMEOUT     64   max cycles spent in WAIT_BUSY+WAIT_DONE before the job is aborted; >=4
// PORTS
//   clka         in   1                      single clock; all state on rising edge
//   reset        in   1                      asynchronous, active-high; clears all state
//   cmd_valid    in   1                      job offered
//   cmd_ready    out  1                      job accepted when cmd_valid&cmd_ready
//   cmd_mode     in   1                      cordic_mode for the job
//   cmd_x        in   DATA_W                 operand to core in_port0
//   cmd_y        in   DATA_W                 operand to core in_port1
//   rsp_valid    out  1                      result available
//   rsp_ready    in   1                      result consumed when rsp_valid&rsp_ready
//   rsp_p0       out  DATA_W                 captured core out_port0
//   rsp_p1       out  DATA_W                 captured core out_port1
//   rsp_mode     out  1                      mode of the job that produced this result
//   rsp_err      out  1                      1 = job timed out; p0/p1 = 0
//   core_start   out  1                      to core start; one-cycle pulse
//   core_mode    out  1                      to core cordic_mode
//   core_in0     out  DATA_W                 to core in_port0
//   core_in1     out  DATA_W                 to core in_port1
//   core_out0    in   DATA_W                 from core out_port0
//   core_out1    in   DATA_W                 from core out_port1
//   core_done    in   1                      from core done (level; high while the core holds its result)
//   busy         out  1                      FSM not in IDLE
//   fifo_count   out  $clog2(FIFO_DEPTH)+1   jobs queued
// BEHAVIOUR
//   Reset values: cmd_ready=1 and fifo_count=0. All other outputs are 0, FSM=IDLE.
//   All outputs are registered except cmd_ready, which is decoded as !full from the registered count.
//   FIFO
//     - push on cmd_valid&cmd_ready; when full, cmd_ready=0 and cmd_valid is ignored.
//     - pop only in IDLE when not empty.
//     - push and pop in the same cycle leave the count unchanged.
//     - read and write pointers wrap modulo FIFO_DEPTH.
//   FSM (states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP)
//     IDLE: if !empty, pop the job into core_mode/core_in0/core_in1 -> LAUNCH.
//     LAUNCH: core_start=1 for exactly this cycle; clear tmo_cnt -> WAIT_BUSY.
//     WAIT_BUSY: wait for core_done=0, which discards a stale done from the previous job -> WAIT_DONE.
//     WAIT_DONE: on core_done=1, capture core_out0/1 into rsp_p0/p1, rsp_mode=core_mode, rsp_err=0 -> RESP.
//     Timeout: tmo_cnt increments each cycle in WAIT_BUSY or WAIT_DONE.
//       - when tmo_cnt reaches TIMEOUT-1 and the state's exit condition is not met: rsp_err=1, rsp_p0=rsp_p1=0 -> RESP.
//       - if the exit condition is met on that same cycle, normal completion wins.
//     RESP: rsp_valid=1, holding payload stable until rsp_ready; on the handshake rsp_valid=0 -> IDLE.
//     Next job: launch is earliest 1 cycle after the handshake. Minimum spacing is LAUNCH to LAUNCH >= 5 cycles.
//   core_mode/core_in0/core_in1 are held constant from LAUNCH until the next IDLE pop.
//   Latency: cmd accept (empty FIFO, IDLE) -> core_start = 2 cycles.
//   Reset mid-job
//     - core_start is deasserted immediately (async).
//     - the FIFO is flushed and no rsp is produced.
//     - the core is reset by the same reset net.
// STRUCTURE
//   cordic_pkg: DATA_W default, state enum cordic_seq_state_t, TIMEOUT default.
//   Sub-module cordic_cmd_fifo: parameterised (DATA_W*2+1)-bit sync FIFO with async reset, push/pop/full/empty/count.
//   Top: FSM, timeout counter, response registers.
// TESTING
//   1. Single job: mode=1, x=8'h40, y=8'h00, rsp_ready=1, model done high 16 cycles after start.
//      -> one core_start pulse; rsp_p0/p1 equal the model's outputs; rsp_err=0, rsp_mode=1.
//   2. Burst: push 5 jobs back-to-back while core_done is held stalled.
//      -> cmd_ready falls after 4 accepts; fifo_count=4; the 5th is accepted after the first pop; results come out in order.
//   3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
//      -> payload stable, no new core_start until the handshake.
//   4. Timeout: core_done stuck 0, TIMEOUT=64.
//      -> rsp_valid 64 cycles after WAIT_BUSY entry with rsp_err=1 and p0=p1=0; next job still runs.
//   5. Stale done: core_done held 1 across LAUNCH, falls 3 cycles later, rises 10 cycles after that.
//      -> result captured only on the second rise.
//   6. Reset in WAIT_DONE with 2 jobs queued.
//      -> all outputs at reset values next edge; fifo_count=0; no rsp_valid.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared defaults and FSM state type for the CORDIC job sequencer.
package cordic_pkg;

  localparam int CORDIC_DATA_W     = 8;
  localparam int CORDIC_FIFO_DEPTH = 4;
  localparam int CORDIC_TIMEOUT    = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } cordic_seq_state_t;

endpackage

// File: rtl/cordic_cmd_fifo.sv
// Synchronous job FIFO. Push is ignored when full, pop is ignored when empty.
module cordic_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clka,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cordic_job_sequencer.sv
// Feeds queued (mode, x, y) jobs to the CORDIC core one at a time and returns
// each result, tagged with mode and a timeout flag, on a valid/ready port.
//
// state     | meaning
// IDLE      | waiting for a queued job; pops it into the core operand registers
// LAUNCH    | core_start high for this single cycle; timeout counter cleared
// WAIT_BUSY | waiting for core_done to drop (discards previous job's done)
// WAIT_DONE | waiting for core_done to rise; captures core outputs
// RESP      | result held on rsp_* until rsp_ready
module cordic_job_sequencer
  import cordic_pkg::*;
#(
  parameter int DATA_W     = CORDIC_DATA_W,
  parameter int FIFO_DEPTH = CORDIC_FIFO_DEPTH,
  parameter int TIMEOUT    = CORDIC_TIMEOUT
) (
  input  logic                          clka,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_mode,
  input  logic [DATA_W-1:0]             cmd_x,
  input  logic [DATA_W-1:0]             cmd_y,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_p0,
  output logic [DATA_W-1:0]             rsp_p1,
  output logic                          rsp_mode,
  output logic                          rsp_err,
  output logic                          core_start,
  output logic                          core_mode,
  output logic [DATA_W-1:0]             core_in0,
  output logic [DATA_W-1:0]             core_in1,
  input  logic [DATA_W-1:0]             core_out0,
  input  logic [DATA_W-1:0]             core_out1,
  input  logic                          core_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int JOB_W = 2 * DATA_W + 1;
  localparam int TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  cordic_seq_state_t state, next_state;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [JOB_W-1:0] fifo_rd;
  logic [TW-1:0]    tmo_cnt;
  logic             in_wait;
  logic             tmo_hit;
  logic             capture_ok;
  logic             abort;

  assign cmd_ready = !fifo_full;

  cordic_cmd_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka    (clka),
    .reset   (reset),
    .push    (cmd_valid && cmd_ready),
    .wr_data ({cmd_mode, cmd_x, cmd_y}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clka or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Exit conditions are tested before the timeout so a completion on the
  // last allowed cycle is still reported as a good result.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    capture_ok = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH:    next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!core_done) begin
          next_state = WAIT_DONE;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = RESP;
        end
      end
      WAIT_DONE: begin
        if (core_done) begin
          capture_ok = 1'b1;
          next_state = RESP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      core_in0   <= '0;
      core_in1   <= '0;
      busy       <= 1'b0;
      tmo_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_p0     <= '0;
      rsp_p1     <= '0;
      rsp_mode   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      core_start <= (next_state == LAUNCH);
      busy       <= (next_state != IDLE);
      if (fifo_pop) {core_mode, core_in0, core_in1} <= fifo_rd;

      if (state == LAUNCH) tmo_cnt <= '0;
      else if (in_wait)    tmo_cnt <= tmo_cnt + 1'b1;

      if (capture_ok) begin
        rsp_valid <= 1'b1;
        rsp_p0    <= core_out0;
        rsp_p1    <= core_out1;
        rsp_mode  <= core_mode;
        rsp_err   <= 1'b0;
      end else if (abort) begin
        rsp_valid <= 1'b1;
        rsp_p0    <= '0;
        rsp_p1    <= '0;
        rsp_mode  <= core_mode;
        rsp_err   <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Directed bench for cordic_job_sequencer with a small behavioural CORDIC core stand-in.
module tb_cordic_job_sequencer;

  localparam int DW = 8;

  logic          clka = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_mode;
  logic [DW-1:0] cmd_x, cmd_y;
  logic          rsp_valid, rsp_ready, rsp_mode, rsp_err;
  logic [DW-1:0] rsp_p0, rsp_p1;
  logic          core_start, core_mode, core_done, busy;
  logic [DW-1:0] core_in0, core_in1, core_out0, core_out1;
  logic [2:0]    fifo_count;

  always #5 clka = ~clka;

  cordic_job_sequencer #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clka(clka), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p0(rsp_p0), .rsp_p1(rsp_p1),
    .rsp_mode(rsp_mode), .rsp_err(rsp_err),
    .core_start(core_start), .core_mode(core_mode), .core_in0(core_in0), .core_in1(core_in1),
    .core_out0(core_out0), .core_out1(core_out1), .core_done(core_done),
    .busy(busy), .fifo_count(fifo_count)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int acc_cyc = 0;

  always @(posedge clka) cyc <= cyc + 1;
  always @(negedge clka) if (core_start) begin
    start_cnt      <= start_cnt + 1;
    last_start_cyc <= cyc;
  end

  // Core stand-in: out0 = mode ? in0+in1 : in0-in1, out1 = in0^in1.
  function automatic logic [7:0] f0(input logic m, input logic [7:0] a, input logic [7:0] b);
    return m ? a + b : a - b;
  endfunction

  logic          m_stall = 1'b0, m_man = 1'b0, m_man_done = 1'b0;
  logic [DW-1:0] m_man_o0 = '0, m_man_o1 = '0;
  int            m_delay = 4;
  logic          m_done, m_armed;
  logic [DW-1:0] m_o0, m_o1;
  int            m_cnt;

  always @(posedge clka or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0; m_armed <= 1'b0; m_o0 <= '0; m_o1 <= '0; m_cnt <= 0;
    end else if (core_start) begin
      m_done <= 1'b0; m_cnt <= m_delay; m_armed <= 1'b1;
    end else if (m_armed && !m_stall) begin
      if (m_cnt <= 1) begin
        m_done  <= 1'b1;
        m_o0    <= f0(core_mode, core_in0, core_in1);
        m_o1    <= core_in0 ^ core_in1;
        m_armed <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign core_done = m_man ? m_man_done : m_done;
  assign core_out0 = m_man ? m_man_o0 : m_o0;
  assign core_out1 = m_man ? m_man_o1 : m_o1;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic       mode;
    logic       err;
  } rsp_t;
  rsp_t rsp_q[$];

  always @(negedge clka)
    if (!reset && rsp_valid && rsp_ready)
      rsp_q.push_back('{rsp_p0, rsp_p1, rsp_mode, rsp_err});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic m, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    cmd_valid = 1'b1; cmd_mode = m; cmd_x = x; cmd_y = y;
    while (!cmd_ready && n < 300) begin
      @(negedge clka);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
    acc_cyc = cyc;
    @(negedge clka);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int limit);
    int k = 0;
    while (rsp_q.size() < n && k < limit) begin
      @(negedge clka);
      k++;
    end
    if (rsp_q.size() < n) chk("rsp_wait_timeout", rsp_q.size(), n);
  endtask

  task automatic check_rsp(input string tag, input logic m, input logic [7:0] p0,
                           input logic [7:0] p1, input logic err);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      r = rsp_q.pop_front();
      chk({tag, "_p0"}, r.p0, p0);
      chk({tag, "_p1"}, r.p1, p1);
      chk({tag, "_mode"}, r.mode, m);
      chk({tag, "_err"}, r.err, err);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] x;
    logic [7:0] y;
    int         delay;
    logic [7:0] p0;
    logic [7:0] p1;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic       bm[6];
    logic [7:0] bx[6], by[6];
    logic [7:0] hp0, hp1;
    logic       hmode, herr;
    int s0, k, seen, vcyc, unstable;

    vecs[0] = '{1'b1, 8'h40, 8'h00, 16, 8'h40, 8'h40};
    vecs[1] = '{1'b0, 8'h30, 8'h10, 3,  8'h20, 8'h20};
    vecs[2] = '{1'b1, 8'hF0, 8'h20, 1,  8'h10, 8'hD0};
    vecs[3] = '{1'b0, 8'h05, 8'h0A, 7,  8'hFB, 8'h0F};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 2,  8'hFE, 8'h00};
    bm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bx = '{8'h11, 8'h10, 8'h7F, 8'h00, 8'hAA, 8'h80};
    by = '{8'h22, 8'h01, 8'h01, 8'h01, 8'h55, 8'h80};

    cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_x = '0; cmd_y = '0; rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clka);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b0;
    @(negedge clka);

    // Single jobs from the vector table
    for (int i = 0; i < 5; i++) begin
      m_delay = vecs[i].delay;
      s0 = start_cnt;
      send(vecs[i].mode, vecs[i].x, vecs[i].y);
      wait_rsp(1, 200);
      check_rsp($sformatf("vec%0d", i), vecs[i].mode, vecs[i].p0, vecs[i].p1, 1'b0);
      repeat (2) @(negedge clka);
      chk($sformatf("vec%0d_starts", i), start_cnt - s0, 1);
      chk($sformatf("vec%0d_idle", i), busy, 0);
      if (i == 0) chk("launch_latency", last_start_cyc - acc_cyc, 2);
    end

    // Burst into a busy sequencer: FIFO fills at 4, 5th waits for a pop
    m_delay = 2; m_stall = 1'b1;
    s0 = start_cnt;
    send(bm[0], bx[0], by[0]);
    repeat (3) @(negedge clka);
    chk("burst_busy", busy, 1);
    chk("burst_fifo_empty", fifo_count, 0);
    fork
      begin
        for (int j = 1; j < 6; j++) send(bm[j], bx[j], by[j]);
      end
      begin
        repeat (4) @(negedge clka);
        chk("burst_count_full", fifo_count, 4);
        chk("burst_ready_low", cmd_ready, 0);
        repeat (3) @(negedge clka);
        chk("burst_5th_held", fifo_count, 4);
        m_stall = 1'b0;
      end
    join
    wait_rsp(6, 400);
    for (int j = 0; j < 6; j++)
      check_rsp($sformatf("burst%0d", j), bm[j], f0(bm[j], bx[j], by[j]), bx[j] ^ by[j], 1'b0);
    repeat (2) @(negedge clka);
    chk("burst_starts", start_cnt - s0, 6);

    // Response backpressure with a second job queued behind
    m_delay = 3; rsp_ready = 1'b0;
    s0 = start_cnt;
    send(1'b1, 8'h21, 8'h12);
    send(1'b0, 8'h50, 8'h05);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clka);
      k++;
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    hp0 = rsp_p0; hp1 = rsp_p1; hmode = rsp_mode; herr = rsp_err;
    chk("bp_held_p0", hp0, 8'h33);
    unstable = 0;
    repeat (10) begin
      @(negedge clka);
      if (!rsp_valid || rsp_p0 != hp0 || rsp_p1 != hp1 || rsp_mode != hmode || rsp_err != herr)
        unstable++;
    end
    chk("bp_payload_stable", unstable, 0);
    chk("bp_no_new_start", start_cnt - s0, 1);
    rsp_ready = 1'b1;
    wait_rsp(2, 200);
    check_rsp("bp_first", 1'b1, 8'h33, 8'h33, 1'b0);
    check_rsp("bp_second", 1'b0, 8'h4B, 8'h55, 1'b0);

    // Timeout: done never rises
    m_stall = 1'b1;
    send(1'b1, 8'h0F, 8'hF0);
    k = 0;
    while (!rsp_valid && k < 300) begin
      @(negedge clka);
      k++;
    end
    vcyc = cyc;
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_latency", vcyc - last_start_cyc, 65);
    wait_rsp(1, 20);
    check_rsp("tmo", 1'b1, 8'h00, 8'h00, 1'b1);
    m_stall = 1'b0; m_delay = 2;
    send(1'b0, 8'h09, 8'h03);
    wait_rsp(1, 100);
    check_rsp("after_tmo", 1'b0, 8'h06, 8'h0A, 1'b0);

    // Stale done: high across LAUNCH, low 3 cycles later, new result 10 cycles after
    m_man = 1'b1; m_man_done = 1'b1; m_man_o0 = 8'hDE; m_man_o1 = 8'hAD;
    send(1'b1, 8'h01, 8'h02);
    k = 0;
    while (!core_start && k < 20) begin
      @(negedge clka);
      k++;
    end
    chk("stale_start_seen", core_start, 1);
    seen = 0;
    repeat (3) begin
      @(negedge clka);
      if (rsp_valid) seen++;
    end
    m_man_done = 1'b0;
    repeat (10) begin
      @(negedge clka);
      if (rsp_valid) seen++;
    end
    chk("stale_no_early_rsp", seen, 0);
    m_man_o0 = 8'h77; m_man_o1 = 8'h88; m_man_done = 1'b1;
    wait_rsp(1, 50);
    check_rsp("stale", 1'b1, 8'h77, 8'h88, 1'b0);
    repeat (2) @(negedge clka);
    m_man = 1'b0;

    // Reset while waiting on the core with two jobs queued
    m_stall = 1'b1; m_delay = 2;
    send(1'b0, 8'h01, 8'h01);
    send(1'b0, 8'h02, 8'h02);
    send(1'b0, 8'h03, 8'h03);
    repeat (2) @(negedge clka);
    chk("prerst_count", fifo_count, 2);
    chk("prerst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_core_in0", core_in0, 0);
    chk("midrst_rsp_p0", rsp_p0, 0);
    @(negedge clka);
    reset = 1'b0;
    m_stall = 1'b0;
    s0 = start_cnt;
    seen = 0;
    repeat (12) begin
      @(negedge clka);
      if (rsp_valid) seen++;
    end
    chk("postrst_no_rsp", seen, 0);
    chk("postrst_no_start", start_cnt - s0, 0);
    chk("postrst_queue", rsp_q.size(), 0);
    send(1'b1, 8'h03, 8'h04);
    wait_rsp(1, 100);
    check_rsp("postrst_job", 1'b1, 8'h07, 8'h07, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
